// File: rtl/knn_local_buf_ctrl_pkg.sv
// Shared definitions for the KNN local buffer controller.
// Holds the controller state encoding and the output FIFO depth helper.
// The FIFO depth is one more than the memory read latency so a full
// pipeline of in-flight reads plus one stalled word can always be held.
package knn_local_buf_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int DEFAULT_READ_LATENCY = 2;
   localparam int FIFO_DEPTH           = DEFAULT_READ_LATENCY + 1;

   function automatic int fifo_depth(input int read_latency);
      return read_latency + 1;
   endfunction

endpackage

// File: rtl/knn_local_buf_ctrl_fifo.sv
// knn_fwft_fifo: first-word-fall-through FIFO for the drain stream.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write side (no full flag; the caller's credit
//                     scheme guarantees it never overflows)
//   pop               consume the head word (ignored when not valid)
//   valid, head       not-empty flag and head word
// An empty FIFO passes push_data straight to head so a word returning
// from memory is visible in the same cycle it arrives.
module knn_fwft_fifo
   import knn_local_buf_ctrl_pkg::*;
#(
   parameter int Width = 256,
   parameter int Depth = FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [Width-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [Width-1:0] head
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic [CntW-1:0]  count;
   logic             empty;
   logic             bypass;
   logic             store;
   logic             deq;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty  = (count == '0);
   assign bypass = empty & push;
   assign valid  = ~empty | push;
   assign head   = bypass ? push_data : mem[rd_ptr];
   // A word that bypasses and is consumed in the same cycle is never stored.
   assign store  = push & ~(bypass & pop);
   assign deq    = pop & ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < Depth; i++) mem[i] <= '0;
      end else begin
         if (store) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (deq) rd_ptr <= next_ptr(rd_ptr);
         count <= count + CntW'(store) - CntW'(deq);
      end
   end

endmodule

// File: rtl/knn_local_buf_ctrl.sv
// knn_local_buf_ctrl: fills a local single-port memory from a stream,
// then drains the same words back out as a stream.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   start, len, busy, done   command interface (len clipped to AddressRange)
//   wr_valid/ready/data      fill stream
//   rd_valid/ready/data      drain stream
//   mem_*0                   single memory port, this block is initiator
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | waiting for start
// ST_FILL  | accepting L beats, writing address 0..L-1
// ST_DRAIN | reading 0..L-1, streaming them out in order
// ST_DONE  | one-cycle done pulse, back to idle
module knn_local_buf_ctrl
   import knn_local_buf_ctrl_pkg::*;
#(
   parameter int DataWidth    = 256,
   parameter int AddressRange = 2048,
   parameter int AddressWidth = 11,
   parameter int ReadLatency  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [AddressWidth:0]   len,
   output logic                    busy,
   output logic                    done,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [DataWidth-1:0]    wr_data,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [DataWidth-1:0]    rd_data,
   output logic [AddressWidth-1:0] mem_address0,
   output logic                    mem_ce0,
   output logic                    mem_we0,
   output logic [DataWidth-1:0]    mem_d0,
   input  logic [DataWidth-1:0]    mem_q0
);

   localparam int FifoDepth = fifo_depth(ReadLatency);
   localparam int CreditW   = $clog2(FifoDepth + 1);
   localparam logic [AddressWidth:0] MaxLen = (AddressWidth + 1)'(AddressRange);

   state_t                  state;
   logic [AddressWidth:0]   len_q;
   logic [AddressWidth:0]   len_clip;
   logic [AddressWidth:0]   wr_cnt;
   logic [AddressWidth:0]   iss_cnt;
   logic [AddressWidth:0]   rd_cnt;
   logic [CreditW-1:0]      credits;
   logic [ReadLatency-1:0]  vsr;
   logic [AddressWidth-1:0] addr_q;
   logic [DataWidth-1:0]    d_q;
   logic                    fill_hs;
   logic                    issue;
   logic                    rd_hs;
   logic                    fifo_valid;

   assign len_clip = (len > MaxLen) ? MaxLen : len;
   assign wr_ready = (state == ST_FILL);
   assign fill_hs  = wr_valid & wr_ready;
   // Credits cover in-flight reads plus buffered words, so issue can never
   // overrun the FIFO even if rd_ready drops for a long time.
   assign issue    = (state == ST_DRAIN) && (iss_cnt < len_q) &&
                     (credits < CreditW'(FifoDepth));
   assign rd_valid = (state == ST_DRAIN) && fifo_valid;
   assign rd_hs    = rd_valid & rd_ready;

   assign mem_ce0      = fill_hs | issue;
   assign mem_we0      = fill_hs;
   // Address and write data hold their last driven value when the port idles.
   assign mem_address0 = fill_hs ? wr_cnt[AddressWidth-1:0] :
                         issue   ? iss_cnt[AddressWidth-1:0] : addr_q;
   assign mem_d0       = fill_hs ? wr_data : d_q;

   knn_fwft_fifo #(
      .Width (DataWidth),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (vsr[ReadLatency-1]),
      .push_data (mem_q0),
      .pop       (rd_hs),
      .valid     (fifo_valid),
      .head      (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         len_q   <= '0;
         wr_cnt  <= '0;
         iss_cnt <= '0;
         rd_cnt  <= '0;
         credits <= '0;
         vsr     <= '0;
         addr_q  <= '0;
         d_q     <= '0;
      end else begin
         vsr[0] <= issue;
         for (int i = 1; i < ReadLatency; i++) vsr[i] <= vsr[i-1];
         credits <= credits + CreditW'(issue) - CreditW'(rd_hs);
         if (mem_ce0) addr_q <= mem_address0;
         if (fill_hs) d_q <= wr_data;
         done <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  len_q   <= len_clip;
                  wr_cnt  <= '0;
                  iss_cnt <= '0;
                  rd_cnt  <= '0;
                  busy    <= 1'b1;
                  if (len_clip == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_FILL;
                  end
               end
            end
            ST_FILL: begin
               if (fill_hs) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == len_q - 1'b1) state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (issue) iss_cnt <= iss_cnt + 1'b1;
               if (rd_hs) begin
                  rd_cnt <= rd_cnt + 1'b1;
                  if (rd_cnt == len_q - 1'b1) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_knn_local_buf_ctrl.sv
module tb_knn_local_buf_ctrl;

   localparam int DW = 256;
   localparam int AR = 2048;
   localparam int AW = 11;
   localparam int RL = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   len = '0;
   logic          busy;
   logic          done;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] mem_address0;
   logic          mem_ce0;
   logic          mem_we0;
   logic [DW-1:0] mem_d0;
   logic [DW-1:0] mem_q0;

   knn_local_buf_ctrl #(
      .DataWidth(DW), .AddressRange(AR), .AddressWidth(AW), .ReadLatency(RL)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy), .done(done),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
      .mem_d0(mem_d0), .mem_q0(mem_q0)
   );

   always #5 clk = ~clk;

   // memory model with RL-cycle read latency
   logic [DW-1:0] mem_model [AR];
   logic [DW-1:0] rpipe [RL];
   always @(posedge clk) begin
      if (mem_ce0 && mem_we0) mem_model[mem_address0] <= mem_d0;
      if (mem_ce0 && !mem_we0) rpipe[0] <= mem_model[mem_address0];
      else rpipe[0] <= {64{4'hB}};
      for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
   end
   assign mem_q0 = rpipe[RL-1];

   int errors = 0;
   int checks = 0;
   int cyc_n  = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard and per-command monitor counters
   logic [DW-1:0] sb [$];
   logic [DW-1:0] exp_word;
   logic [DW-1:0] last_wd;
   int wr_n, iss_n, beats, ce_n, done_n;
   int first_wr, last_wr, first_iss, last_iss, first_rv, last_beat, done_cyc;

   always @(negedge clk) begin
      if (!reset) begin
         if (mem_ce0 && mem_we0) begin
            check("wr_addr", DW'(mem_address0), DW'(wr_n));
            sb.push_back(wr_data);
            last_wd = wr_data;
            if (wr_n == 0) first_wr = cyc_n;
            last_wr = cyc_n;
            wr_n++;
         end
         if (mem_ce0 && !mem_we0) begin
            check("rd_addr", DW'(mem_address0), DW'(iss_n));
            if (iss_n == 0) first_iss = cyc_n;
            last_iss = cyc_n;
            iss_n++;
         end
         if (mem_ce0) ce_n++;
         if (mem_we0 && !mem_ce0) check("we_without_ce", DW'(mem_we0), DW'(mem_ce0));
         if (rd_valid && first_rv < 0) first_rv = cyc_n;
         if (rd_valid && rd_ready) begin
            check("sb_nonempty", DW'(sb.size() != 0), DW'(1));
            if (sb.size() != 0) begin
               exp_word = sb.pop_front();
               check("rd_data", rd_data, exp_word);
            end
            beats++;
            last_beat = cyc_n;
         end
         if (wr_ready && rd_valid) check("wr_rd_excl", DW'(1), DW'(0));
         if (done) begin
            done_n++;
            done_cyc = cyc_n;
         end
      end
   end

   bit rand_valid = 0;
   bit rand_ready = 0;

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         wr_data = rand_word();
         if (rand_valid) wr_valid = ($urandom % 2) != 0;
         if (rand_ready) rd_ready = ($urandom % 4) != 0;
      end
   endtask

   task automatic clear_mon();
      wr_n = 0; iss_n = 0; beats = 0; ce_n = 0; done_n = 0;
      first_wr = -1; last_wr = -1; first_iss = -1; last_iss = -1;
      first_rv = -1; last_beat = -1; done_cyc = -1;
   endtask

   task automatic cmd(input int l);
      start = 1'b1;
      len   = (AW+1)'(l);
      run(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_n == 0 && n < budget) begin
         run(1);
         n++;
      end
      check(tag, DW'(done_n != 0), DW'(1));
      run(2);
   endtask

   task automatic wait_issue(input string tag, input int budget);
      int n = 0;
      while (iss_n == 0 && n < budget) begin
         run(1);
         n++;
      end
      check(tag, DW'(iss_n != 0), DW'(1));
   endtask

   initial begin
      clear_mon();
      run(3);
      reset = 1'b0;
      // state after reset
      check("rst_busy", DW'(busy), DW'(0));
      check("rst_done", DW'(done), DW'(0));
      check("rst_wr_ready", DW'(wr_ready), DW'(0));
      check("rst_rd_valid", DW'(rd_valid), DW'(0));
      check("rst_ce", DW'(mem_ce0), DW'(0));
      check("rst_we", DW'(mem_we0), DW'(0));
      check("rst_addr", DW'(mem_address0), DW'(0));
      check("rst_d0", mem_d0, DW'(0));
      check("rst_rd_data", rd_data, DW'(0));

      // L=4, full-rate streams
      clear_mon();
      wr_valid = 1'b1; rd_ready = 1'b1;
      cmd(4);
      check("t1_busy", DW'(busy), DW'(1));
      wait_done("t1_done_timeout", 50);
      check("t1_writes", DW'(wr_n), DW'(4));
      check("t1_wr_consec", DW'(last_wr - first_wr), DW'(3));
      check("t1_fill_to_drain", DW'(first_iss - last_wr), DW'(1));
      check("t1_issues", DW'(iss_n), DW'(4));
      check("t1_rd_consec", DW'(last_iss - first_iss), DW'(3));
      check("t1_first_rv_lat", DW'(first_rv - first_iss), DW'(RL));
      check("t1_beats", DW'(beats), DW'(4));
      check("t1_beat_consec", DW'(last_beat - first_rv), DW'(3));
      check("t1_done_lat", DW'(done_cyc - last_beat), DW'(1));
      check("t1_done_width", DW'(done_n), DW'(1));
      check("t1_sb_empty", DW'(sb.size()), DW'(0));
      check("t1_idle_busy", DW'(busy), DW'(0));
      check("t1_idle_ce", DW'(mem_ce0), DW'(0));
      check("t1_idle_we", DW'(mem_we0), DW'(0));
      check("t1_idle_addr_hold", DW'(mem_address0), DW'(3));
      check("t1_idle_d0_hold", mem_d0, last_wd);

      // L=8, drain back-pressured for 10 cycles
      clear_mon();
      rd_ready = 1'b0; rand_valid = 1;
      cmd(8);
      wait_issue("t2_issue_timeout", 100);
      run(9);
      check("t2_stalled_issues", DW'(iss_n), DW'(RL + 1));
      check("t2_stalled_beats", DW'(beats), DW'(0));
      check("t2_stalled_rv", DW'(rd_valid), DW'(1));
      rd_ready = 1'b1; rand_valid = 0; wr_valid = 1'b1;
      wait_done("t2_done_timeout", 100);
      check("t2_writes", DW'(wr_n), DW'(8));
      check("t2_issues", DW'(iss_n), DW'(8));
      check("t2_beats", DW'(beats), DW'(8));
      check("t2_sb_empty", DW'(sb.size()), DW'(0));

      // len=0
      clear_mon();
      cmd(0);
      check("t3_done_next", DW'(done), DW'(1));
      run(3);
      check("t3_no_ce", DW'(ce_n), DW'(0));
      check("t3_done_width", DW'(done_n), DW'(1));
      check("t3_busy", DW'(busy), DW'(0));

      // len beyond AddressRange is clipped
      clear_mon();
      rand_ready = 1;
      cmd(4000);
      wait_done("t4_done_timeout", 12000);
      rand_ready = 0; rd_ready = 1'b1;
      check("t4_writes", DW'(wr_n), DW'(AR));
      check("t4_issues", DW'(iss_n), DW'(AR));
      check("t4_beats", DW'(beats), DW'(AR));
      check("t4_sb_empty", DW'(sb.size()), DW'(0));

      // reset mid-drain with two reads in flight
      clear_mon();
      rd_ready = 1'b0;
      cmd(8);
      wait_issue("t5_issue_timeout", 100);
      reset = 1'b1;
      run(1);
      check("t5_busy", DW'(busy), DW'(0));
      check("t5_rd_valid", DW'(rd_valid), DW'(0));
      reset = 1'b0;
      rd_ready = 1'b1;
      run(4);
      check("t5_rd_valid_late", DW'(rd_valid), DW'(0));
      check("t5_no_done", DW'(done_n), DW'(0));
      check("t5_no_beats", DW'(beats), DW'(0));
      sb.delete();
      clear_mon();
      cmd(2);
      wait_done("t5_done_timeout", 50);
      check("t5_writes", DW'(wr_n), DW'(2));
      check("t5_beats", DW'(beats), DW'(2));
      check("t5_sb_empty", DW'(sb.size()), DW'(0));

      // start during FILL is ignored
      clear_mon();
      wr_valid = 1'b0;
      cmd(5);
      wr_valid = 1'b1;
      run(2);
      start = 1'b1; len = (AW+1)'(3); wr_valid = 1'b0;
      run(1);
      start = 1'b0; wr_valid = 1'b1;
      wait_done("t6_done_timeout", 50);
      check("t6_writes", DW'(wr_n), DW'(5));
      check("t6_issues", DW'(iss_n), DW'(5));
      check("t6_beats", DW'(beats), DW'(5));
      check("t6_done_width", DW'(done_n), DW'(1));
      check("t6_sb_empty", DW'(sb.size()), DW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/knn_local_buf_ctrl.md
KNN_LOCAL_BUF_CTRL -- requirements
Module: knn_local_buf_ctrl

Interface
REQ-001 Parameters: DataWidth, default 256, word width; AddressRange, default 2048, memory depth; AddressWidth, default 11, address width; ReadLatency, default 2, memory read latency in cycles (>=1).
REQ-002 Ports, in order:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse.
- len  in  AddressWidth+1  beat count for the command.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle completion pulse.
- wr_valid  in  1  fill-stream valid.
- wr_ready  out  1  fill-stream ready.
- wr_data  in  DataWidth  fill-stream data.
- rd_valid  out  1  drain-stream valid.
- rd_ready  in  1  drain-stream ready.
- rd_data  out  DataWidth  drain-stream data.
- mem_address0  out  AddressWidth  memory address.
- mem_ce0  out  1  memory enable.
- mem_we0  out  1  memory write enable.
- mem_d0  out  DataWidth  memory write data.
- mem_q0  in  DataWidth  memory read data.
REQ-003 The block drives the single memory port (address0/ce0/we0/d0/q0) as initiator; mem_q0 is valid exactly ReadLatency cycles after a cycle with mem_ce0=1, mem_we0=0.

Function
REQ-004 States: IDLE, FILL, DRAIN, DONE.
REQ-005 IDLE: start=1 latches L=min(len, AddressRange) and enters FILL next cycle; if L=0, enters DONE instead; start in any other state is ignored.
REQ-006 FILL: wr_ready=1; each wr_valid&wr_ready beat k (0-based) writes wr_data at address k in the same cycle (mem_ce0=mem_we0=1, combinational from handshake).
REQ-007 FILL -> DRAIN in the cycle after beat L-1.
REQ-008 DRAIN: issue reads to addresses 0..L-1 in order (mem_ce0=1, mem_we0=0); a read is issued only when issued<L and credits<ReadLatency+1.
REQ-009 credits = reads in flight + words held in the output FIFO; +1 on issue, -1 on rd handshake, both in the same cycle leaving it unchanged.
REQ-010 A ReadLatency-deep valid shift register tracks in-flight reads; when its tail is set, mem_q0 is pushed into the output FIFO.
REQ-011 Output FIFO: depth ReadLatency+1, first-word-fall-through; rd_valid = not empty; rd_data = head.
REQ-012 With rd_ready held at 1, drain throughput is one beat per cycle; the first rd_valid appears ReadLatency cycles after the first read issue.
REQ-013 rd_ready=0 stalls issue once credits reach ReadLatency+1; no read data is dropped or duplicated.
REQ-014 DRAIN -> DONE in the cycle after the L-th rd handshake.
REQ-015 DONE: done=1 for exactly one cycle, then IDLE.
REQ-016 Idle port values: mem_ce0=0, mem_we0=0, mem_address0 and mem_d0 hold their last values.
REQ-017 wr_ready=0 outside FILL. rd_valid=0 outside DRAIN.
REQ-018 Memory contents are never cleared by the block.

Reset
REQ-019 While reset=1 on a clk edge:
- State -> IDLE.
- Counters, credits, the valid shift register and the FIFO are cleared.
- Outputs: busy=0, done=0, wr_ready=0, rd_valid=0, mem_ce0=0, mem_we0=0, mem_address0=0, mem_d0=0, rd_data=0.
REQ-020 Reset during FILL or DRAIN aborts the command without a done pulse; read data returning after reset is discarded.

Structure
REQ-021 A shared package holds the state enum and the helper constant FIFO_DEPTH=ReadLatency+1.
REQ-022 The output FIFO is the single sub-module, knn_fwft_fifo, parameterised by width and depth.

Verification
REQ-023 L=4, wr_valid always 1, rd_ready always 1, ReadLatency=2 -> writes to addresses 0..3 in 4 consecutive cycles; reads of 0..3 in consecutive cycles; rd_data matches the fill order; done 1 cycle after the 4th rd beat.
REQ-024 L=8, rd_ready=0 for 10 cycles after entering DRAIN -> exactly 3 reads issued, then issue stalls; on release, 8 beats arrive in order with no loss.
REQ-025 len=0 -> done asserted the cycle after start; mem_ce0 never asserted.
REQ-026 len=4000 with AddressRange=2048 -> exactly 2048 writes and 2048 reads; address wraps never.
REQ-027 reset asserted mid-DRAIN with 2 reads in flight -> next cycle busy=0, rd_valid=0; no done pulse; a new L=2 command then completes correctly.
REQ-028 start pulsed during FILL -> ignored; len and the beat count are unchanged.
